pmux_rr_arbiter: RTL
====================

# pmux_rr_arbiter

Round-robin arbiter and sequencer for a parallel (one-hot select) multiplexer shared by N requesters. Each requester offers a W-bit word with a valid/ready handshake. The block grants one requester at a time, drives the one-hot select, and registers the selected word into a single-entry output stage with its own valid/ready handshake. When nothing is granted, the output carries the default word, the same way the pmux default input does. It sits directly in front of the shared pmux datapath and owns its select lines.

## Interface
- N, 3, number of requesters (≥2)
- W, 2, data width per requester
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- dflt  in  W  default word, presented when no grant is held
- req_valid  in  N  requester i has a word
- req_data  in  N*W  requester i word at [i*W +: W]
- req_ready  out  N  one-hot; requester i word accepted this cycle (combinational)
- sel  out  N  registered one-hot select of the word in the output stage; 0 when empty
- out_valid  out  1  output stage holds a word
- out_data  out  W  output word (dflt when empty)
- out_ready  in  1  consumer accepts out_data
- req_lock  in  N  present only with PMUX_ARB_LOCK_EN; requester i requests a burst lock

## Operation
- States: EMPTY (out_valid=0), FULL (out_valid=1), LOCKED (FULL or EMPTY with lock owner; exists only with the macro).
- can_accept = !out_valid | out_ready.
- Winner = first i with req_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- req_ready = onehot(winner) when can_accept and any req_valid; otherwise 0. At most one bit is ever set.
- On accept of i, at the next edge:
  - out_data <= req_data[i], sel <= onehot(i), out_valid <= 1
  - ptr <= (i+1) mod N, wrapping from N-1 to 0
- If out_valid & out_ready and there is no accept, at the next edge: out_valid <= 0, sel <= 0, out_data <= dflt.
- While EMPTY with no accept, out_data follows dflt with one cycle of delay.
- While FULL and !out_ready: out_data, sel and out_valid hold, and req_ready = 0.
- Simultaneous drain and accept (FULL, out_ready=1, winner exists): the new word is loaded and out_valid stays 1. There is no bubble.
- A requester dropping req_valid before it is accepted is legal. Its word is simply not taken.
- No combinational path from req_* to out_*. There is a combinational path out_ready → req_ready.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, sel=0, out_data=0, ptr=0, lock cleared, req_ready=0 during the reset cycle.
- Reset mid-operation discards any held word. There is no drain.
- Latency: accept edge to out_valid=1 is 1 cycle.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0. Every requester is served within N accepts.

## Configuration
- PMUX_ARB_LOCK_EN defined:
  - The req_lock port exists.
  - If req_lock[i]=1 at accept of i, the block enters LOCKED with owner i. ptr is not advanced, and only owner i can win: req_ready is 0 for all others.
  - The lock is released at the next accept of i with req_lock[i]=0, after which ptr <= (i+1) mod N.
  - Reset clears the lock.
- PMUX_ARB_LOCK_EN undefined: no req_lock port, no LOCKED state, pure round-robin as above.

## Test plan
- Reset, then dflt=2 with no requests → out_valid=0, sel=0, req_ready=0, out_data=0 during reset and 2 one cycle after release.
- req_valid=3'b111, req_data=6'b111001 (slot0=1, slot1=2, slot2=3), out_ready=1 held → req_ready sequence 001, 010, 100, 001; out_data 1, 2, 3, 1; sel 001, 010, 100, each 1 cycle after its accept.
- Single req_valid=3'b100 (data 3), out_ready=0 for 4 cycles → one accept. Then out_valid=1, out_data=3, sel=100 and req_ready=0 hold until out_ready=1. One cycle after the drain: out_valid=0, sel=0, out_data=dflt.
- ptr=2 (after granting slot1), req_valid=3'b011 → winner slot0 (wrap-around). Next accept with 3'b011 goes to slot1.
- rst_n=0 while FULL with out_data=2 → next edge out_valid=0, sel=0, out_data=0. After release, req_valid=3'b110 → slot1 granted first (ptr=0).
- With PMUX_ARB_LOCK_EN: req_valid=3'b111, req_lock=3'b001 for 3 accepts then 0 → slot0 wins 4 consecutive accepts (3 locked, the 4th releasing), then slot1, then slot2.

Source files
------------

// File: rtl/pmux_rr_arbiter.sv
// pmux_rr_arbiter
// Round-robin arbiter and sequencer for a one-hot-select parallel multiplexer
// shared by N requesters. The granted word is captured into a single-entry
// output stage with a valid/ready handshake. When no word is held, the stage
// presents the default word, mirroring the pmux default input.
//
// Optional feature: define PMUX_ARB_LOCK_EN to add the req_lock port. A
// requester can then hold the grant across a burst of accepted words.
module pmux_rr_arbiter #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   dflt,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_data,
`ifdef PMUX_ARB_LOCK_EN
   input  logic [N-1:0]   req_lock,
`endif
   output logic [N-1:0]   req_ready,
   output logic [N-1:0]   sel,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   input  logic           out_ready
);

   localparam int            PW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   // Registered state
   logic [PW-1:0] r_ptr;
   logic          r_out_valid;
   logic [N-1:0]  r_sel;
   logic [W-1:0]  r_out_data;
`ifdef PMUX_ARB_LOCK_EN
   logic          r_lock_active;
   logic [PW-1:0] r_lock_owner;
`endif

   // Combinational arbitration signals
   logic [W-1:0]  w_req_word [N];
   logic          w_found;
   logic [PW-1:0] w_winner;
   logic          w_can_accept;
   logic          w_accept;
   logic [N-1:0]  w_grant_onehot;
   logic [PW-1:0] w_ptr_next;

   // Split the flat request bus into one word per requester
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign w_req_word[gi] = req_data[gi*W +: W];
      end
   endgenerate

   // Rotating priority search starting at r_ptr. Scanning from the farthest
   // offset down to zero lets the nearest valid requester overwrite the rest.
   // A held lock restricts the search to the lock owner alone.
   always_comb begin
      int idx;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(r_ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (req_valid[idx]) begin
            w_found  = 1'b1;
            w_winner = PW'(idx);
         end
      end
`ifdef PMUX_ARB_LOCK_EN
      if (r_lock_active) begin
         w_found  = req_valid[r_lock_owner];
         w_winner = r_lock_owner;
      end
`endif
   end

   // The stage can take a word when it is empty or is draining this cycle.
   // Reset gates the grant so no requester sees ready during a reset cycle.
   assign w_can_accept   = !r_out_valid || out_ready;
   assign w_accept       = rst_n && w_can_accept && w_found;
   assign w_grant_onehot = {{(N-1){1'b0}}, 1'b1} << w_winner;
   assign w_ptr_next     = (w_winner == LAST) ? '0 : w_winner + PW'(1);

   assign req_ready = w_accept ? w_grant_onehot : '0;

   // Output stage, round-robin pointer and burst-lock ownership
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr         <= '0;
         r_out_valid   <= 1'b0;
         r_sel         <= '0;
         r_out_data    <= '0;
`ifdef PMUX_ARB_LOCK_EN
         r_lock_active <= 1'b0;
         r_lock_owner  <= '0;
`endif
      end else if (w_accept) begin
         // New word loads even while the previous one drains: no bubble.
         r_out_valid <= 1'b1;
         r_sel       <= w_grant_onehot;
         r_out_data  <= w_req_word[w_winner];
`ifdef PMUX_ARB_LOCK_EN
         if (req_lock[w_winner]) begin
            // Pointer stays put so the burst resumes fairly after release.
            r_lock_active <= 1'b1;
            r_lock_owner  <= w_winner;
         end else begin
            r_lock_active <= 1'b0;
            r_ptr         <= w_ptr_next;
         end
`else
         r_ptr <= w_ptr_next;
`endif
      end else if (r_out_valid && out_ready) begin
         // Drained with nothing to replace it: fall back to the default word.
         r_out_valid <= 1'b0;
         r_sel       <= '0;
         r_out_data  <= dflt;
      end else if (!r_out_valid) begin
         // Idle stage tracks the default word one cycle late.
         r_out_data <= dflt;
      end
   end

   assign out_valid = r_out_valid;
   assign sel       = r_sel;
   assign out_data  = r_out_data;

endmodule
